// File: rtl/prelude_debug_ctrl.sv
// Boot and debug sequencer for the Prelude 8-bit CPU: loads program memory from a
// host byte-command stream and gates core execution (run, halt, step, breakpoint).
module prelude_debug_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_reset,
  output logic              cpu_en,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_wdata,
  output logic              halted,
  output logic              bp_hit,
  output logic              err
);

  localparam logic [2:0] OP_LOAD_MODE = 3'd0;
  localparam logic [2:0] OP_SET_PTR   = 3'd1;
  localparam logic [2:0] OP_WRITE     = 3'd2;
  localparam logic [2:0] OP_RUN       = 3'd3;
  localparam logic [2:0] OP_HALT      = 3'd4;
  localparam logic [2:0] OP_STEP      = 3'd5;
  localparam logic [2:0] OP_SET_BP    = 3'd6;
  localparam logic [2:0] OP_BP_RDPC   = 3'd7;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_HALTED   = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_STEPPING = 2'd3
  } state_t;

  state_t            state, state_d, base_state;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [ADDR_W-1:0] bp_addr, bp_addr_d;
  logic              bp_en, bp_en_d;
  logic              skip, skip_d;
  logic [DATA_W-1:0] count, count_d;
  logic              prog_we_d;
  logic [ADDR_W-1:0] prog_addr_d;
  logic [DATA_W-1:0] prog_wdata_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] resp_data_d;
  logic              err_d;
  logic              active, bp_match, accept, base_idle;

  // Execution gating is combinational so the core stops before the breakpoint instruction.
  always_comb begin
    active    = (state == ST_RUNNING) || (state == ST_STEPPING);
    bp_match  = active && bp_en && (pc == bp_addr) && !skip;
    cpu_en    = active && !bp_match;
    cmd_ready = !resp_valid;
    accept    = cmd_valid && cmd_ready;
  end

  // Next state: execution events (step completion, breakpoint) first, then the command.
  always_comb begin
    base_state   = state;
    ptr_d        = ptr;
    bp_addr_d    = bp_addr;
    bp_en_d      = bp_en;
    skip_d       = skip;
    count_d      = count;
    prog_we_d    = 1'b0;
    prog_addr_d  = prog_addr;
    prog_wdata_d = prog_wdata;
    resp_valid_d = resp_valid;
    resp_data_d  = resp_data;
    err_d        = 1'b0;

    if (cpu_en) begin
      skip_d = 1'b0;
      if (state == ST_STEPPING) begin
        count_d = count - DATA_W'(1);
        if (count == DATA_W'(1)) base_state = ST_HALTED;
      end
    end
    if (bp_match) base_state = ST_HALTED;

    state_d   = base_state;
    base_idle = (base_state == ST_LOAD) || (base_state == ST_HALTED);

    if (resp_valid && resp_ready) resp_valid_d = 1'b0;

    if (accept) begin
      case (cmd_op)
        OP_LOAD_MODE: begin
          state_d = ST_LOAD;
          skip_d  = 1'b0;
        end
        OP_SET_PTR: ptr_d = ADDR_W'(cmd_data);
        OP_WRITE: begin
          if (base_idle) begin
            prog_we_d    = 1'b1;
            prog_addr_d  = ptr;
            prog_wdata_d = cmd_data;
            ptr_d        = ptr + ADDR_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RUN: begin
          if (base_state != ST_RUNNING) state_d = ST_RUNNING;
          if (base_state == ST_HALTED) skip_d = 1'b1;
        end
        OP_HALT: begin
          if (!base_idle) state_d = ST_HALTED;
        end
        OP_STEP: begin
          if (cmd_data != '0) begin
            state_d = ST_STEPPING;
            count_d = cmd_data;
            if (base_state == ST_HALTED) skip_d = 1'b1;
          end
        end
        OP_SET_BP: begin
          bp_addr_d = ADDR_W'(cmd_data);
          bp_en_d   = 1'b1;
        end
        OP_BP_RDPC: begin
          if (cmd_data[0]) begin
            resp_valid_d = 1'b1;
            resp_data_d  = DATA_W'(pc);
          end else begin
            bp_en_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      ptr        <= '0;
      bp_addr    <= '0;
      bp_en      <= 1'b0;
      skip       <= 1'b0;
      count      <= '0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      cpu_reset  <= 1'b1;
      halted     <= 1'b1;
      bp_hit     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      bp_addr    <= bp_addr_d;
      bp_en      <= bp_en_d;
      skip       <= skip_d;
      count      <= count_d;
      prog_we    <= prog_we_d;
      prog_addr  <= prog_addr_d;
      prog_wdata <= prog_wdata_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      cpu_reset  <= (state_d == ST_LOAD);
      halted     <= (state_d == ST_LOAD) || (state_d == ST_HALTED);
      bp_hit     <= bp_match;
      err        <= err_d;
    end
  end

endmodule

// File: doc/prelude_debug_ctrl.md
Name: prelude_debug_ctrl

Overview:
- Boot and debug sequencer for the Prelude 8-bit CPU.
- Loads the program memory from a byte command stream while the core is held in reset.
- Gates core execution with a clock-enable: run, halt, single/multi-step, one hardware breakpoint on pc.
- Sits between a host command port (UART bridge or testbench) and the core's reset, enable and program-memory write port.

Parameters:
ADDR_W, 8, program counter / program memory address width
DATA_W, 8, instruction byte width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  block can accept command
cmd_op  in  3  command opcode
cmd_data  in  DATA_W  command operand
resp_valid  out  1  response valid (READ_PC only)
resp_ready  in  1  host consumes response
resp_data  out  DATA_W  response payload
pc  in  ADDR_W  core program counter (address of instruction about to execute)
cpu_reset  out  1  synchronous reset to core
cpu_en  out  1  core advance enable; one instruction per enabled cycle
prog_we  out  1  program memory write strobe
prog_addr  out  ADDR_W  program memory write address
prog_wdata  out  DATA_W  program memory write data
halted  out  1  core not executing (LOAD or HALTED)
bp_hit  out  1  one-cycle pulse, breakpoint stopped execution
err  out  1  one-cycle pulse, illegal command dropped

Behaviour:
- Reset values: state LOAD, cpu_reset=1, cpu_en=0, prog_we=0, prog_addr=0, prog_wdata=0, load pointer=0, bp disabled, step count=0, resp_valid=0, resp_data=0, halted=1, bp_hit=0, err=0.
- Async reset mid-operation: all of the above take effect immediately; an in-flight prog_we is dropped.
- Handshake:
  - Command accepted when cmd_valid && cmd_ready.
  - cmd_ready = !resp_valid.
  - resp_valid holds with stable resp_data until resp_ready is high; it clears the cycle after.
- States:
  - LOAD: cpu_reset=1, cpu_en=0.
  - HALTED: cpu_reset=0, cpu_en=0.
  - RUNNING / STEPPING: cpu_reset=0, cpu_en = !bp_match.
- bp_match = bp_en && pc==bp_addr && !skip.
  - cpu_en is combinational from registered state, pc and bp registers, so the core halts before executing the breakpoint instruction.
- Opcodes:
  - 0 LOAD_MODE: any state -> LOAD next cycle. Pointer is unchanged.
  - 1 SET_PTR: pointer <= cmd_data.
  - 2 WRITE: legal only in LOAD/HALTED. Next cycle prog_we=1 for exactly one cycle, with prog_addr=pointer and prog_wdata=cmd_data. Pointer then increments, wrapping 2^ADDR_W-1 -> 0. In RUNNING/STEPPING the write is dropped, err pulses, and the pointer is unchanged.
  - 3 RUN: LOAD/HALTED -> RUNNING next cycle. The core starts at the next edge (core pc=0 when leaving LOAD). RUN in RUNNING: no effect. RUN in STEPPING: -> RUNNING.
  - 4 HALT: RUNNING/STEPPING -> HALTED; cpu_en is low from the cycle after accept. In LOAD or HALTED: no effect.
  - 5 STEP n: n=cmd_data.
    - n=0: no-op.
    - Otherwise: -> STEPPING with count=n. Every cycle with cpu_en=1 decrements count; when count reaches 0 -> HALTED. Exactly n instructions execute.
    - STEP in STEPPING reloads count.
  - 6 SET_BP: bp_addr <= cmd_data, bp_en <= 1.
  - 7 CLR_BP (cmd_data[0]=0) or READ_PC (cmd_data[0]=1).
    - CLR_BP: bp_en <= 0.
    - READ_PC: resp_data <= pc as sampled in the accept cycle; resp_valid next cycle. Legal in any state.
- skip is set on entry to RUNNING/STEPPING from HALTED. It clears after the first cycle with cpu_en=1, so the breakpoint instruction executes once on resume.
- bp_match in RUNNING/STEPPING: -> HALTED next cycle, bp_hit pulses, no instruction executes, step count is not decremented.
- Simultaneous breakpoint and accepted command: the breakpoint halt applies first (bp_hit pulses). The command is then applied to the resulting HALTED state.
- halted = (state==LOAD || state==HALTED), registered.

Test Plan:
- Reset, SET_PTR 0x10, WRITE 0xAA, WRITE 0xBB -> prog_we pulses with (0x10,0xAA) then (0x11,0xBB); cpu_reset stays 1; halted=1.
- SET_PTR 0xFF, WRITE 0x01, WRITE 0x02 -> writes land at 0xFF then 0x00 (wrap).
- RUN from LOAD with SET_BP 0x05 -> cpu_reset drops, pc advances 0..4, cpu_en=0 with pc=5, bp_hit single pulse, halted=1; READ_PC returns 0x05.
- From that halt, STEP 3 -> exactly 3 cpu_en cycles (first at pc=5, breakpoint skipped), then HALTED; STEP 0 -> no cpu_en.
- WRITE while RUNNING -> no prog_we, err pulse, pointer unchanged; HALT -> cpu_en low the cycle after accept.
- READ_PC with resp_ready held low 5 cycles -> resp_valid and resp_data stable, cmd_ready=0 throughout; assert reset mid-RUN -> cpu_reset=1, cpu_en=0 and resp_valid=0 immediately.
